// File: rtl/vfd_tspi_scanner.sv
// vfd_tspi_scanner: line scanner for a grid-multiplexed VFD dot-matrix panel.
// On each accepted START it blanks the panel, latches the previously shifted
// line, advances GRID, then streams DOTS pixel bits (fetched from display RAM)
// followed by GRIDS grid-select bits on LANES parallel data lines sharing one
// SCK. GCP pulses are produced from the line SCK count in parallel.
//
// Ports
//   CLK, RST        system clock, synchronous active-high reset
//   START, EN       one-cycle line tick, accepted only with EN=1 while idle
//   MEM_ADDR/CE     display RAM read port (registered RAM, data one CLK later)
//   MEM_DATA        RAM read data, bits [LANES-1:0] used
//   SOUT            serial data, lane k = grayscale bit k
//   SCK             shift clock (panel samples on rising edge)
//   BLK, LAT, GCP   blank, latch, gradient control pulse
//   GRID            current grid index
//   BUSY            high while a line is in progress
//   OVR             sticky flag: START arrived while busy

// One data lane: loads RAM data for pixel bits, the grid pattern for grid
// bits, and returns low at the end of the line.
module vfd_tspi_lane (
  input  logic CLK,
  input  logic RST,
  input  logic ld_mem,
  input  logic ld_grid,
  input  logic clr,
  input  logic mem_bit,
  input  logic grid_bit,
  output logic sout
);
  always_ff @(posedge CLK) begin
    if (RST || clr)   sout <= 1'b0;
    else if (ld_mem)  sout <= mem_bit;
    else if (ld_grid) sout <= grid_bit;
  end
endmodule

module vfd_tspi_scanner #(
  parameter int LANES    = 3,
  parameter int DOTS     = 234,
  parameter int GRIDS    = 52,
  parameter int ADDR_W   = 12,
  parameter int CLK_DIV  = 2,
  parameter int BLK_CYC  = 2,
  parameter int LAT_CYC  = 5,
  parameter int GCP_N    = 6,
  // Entry m lives at [m*9 +: 9]; matching is order-independent.
  parameter logic [GCP_N*9-1:0] GCP_TAB = {9'd72, 9'd144, 9'd192, 9'd216, 9'd240, 9'd256},
  parameter int LINE_SCK = 289
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_CE,
  input  logic [7:0]        MEM_DATA,
  output logic [LANES-1:0]  SOUT,
  output logic              SCK,
  output logic              BLK,
  output logic              LAT,
  output logic              GCP,
  output logic [5:0]        GRID,
  output logic              BUSY,
  output logic              OVR
);
  localparam int BITS  = DOTS + GRIDS;
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int LSC_W = $clog2(LINE_SCK + 1);
  localparam int CMAX  = (BLK_CYC > LAT_CYC) ? BLK_CYC : LAT_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [PH_W-1:0] PH_HI    = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_FETCH = PH_W'(2 * CLK_DIV - 2);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_BLANK, S_LATCH, S_UNBLANK, S_SHIFT, S_HOLD} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PH_W-1:0]    ph, ph_n;      // phase within one SCK period
  logic [LSC_W-1:0]   lsc, lsc_n;    // completed SCK periods this line; also the bit index in SHIFT
  logic [LSC_W-1:0]   nbit;
  logic [5:0]         grid_n, g_use;
  logic               tick, fetch, fetch_q, gcp_n;
  logic               ld_grid, gval, sclr;
  logic               mem_data_unused;

  assign mem_data_unused = ^MEM_DATA;
  assign nbit = lsc + 1'b1;

  function automatic logic tab_hit(input logic [LSC_W-1:0] v);
    tab_hit = 1'b0;
    for (int m = 0; m < GCP_N; m++)
      if (32'(v) == 32'(GCP_TAB[m*9 +: 9])) tab_hit = 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    lsc_n   = lsc;
    grid_n  = GRID;
    tick    = 1'b0;
    case (state)
      S_IDLE:
        if (START && EN) begin
          state_n = S_BLANK;
          cnt_n   = '0;
        end
      S_BLANK:
        if (cnt == CNT_W'(BLK_CYC - 1)) begin
          state_n = S_LATCH;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      S_LATCH:
        if (cnt == CNT_W'(LAT_CYC - 1)) begin
          state_n = S_UNBLANK;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      S_UNBLANK: begin
        state_n = S_SHIFT;
        grid_n  = (GRID == 6'(GRIDS - 1)) ? 6'd0 : GRID + 6'd1;
        ph_n    = '0;
        lsc_n   = '0;
      end
      S_SHIFT, S_HOLD:
        if (state == S_HOLD && lsc >= LSC_W'(LINE_SCK)) state_n = S_IDLE;
        else if (ph == PH_LAST) begin
          // HOLD keeps counting SCK periods with SCK parked low
          tick  = 1'b1;
          ph_n  = '0;
          lsc_n = nbit;
          if (state == S_SHIFT && lsc == LSC_W'(BITS - 1)) state_n = S_HOLD;
        end else ph_n = ph + 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  // Bit 0 is fetched in UNBLANK using the advanced grid; bit i+1 is fetched
  // during the high phase of bit i so its data lands as SCK falls.
  always_comb begin
    fetch    = (state == S_UNBLANK) ||
               (state == S_SHIFT && ph == PH_FETCH && 32'(nbit) < 32'(DOTS));
    g_use    = (state == S_UNBLANK) ? grid_n : GRID;
    MEM_CE   = fetch;
    MEM_ADDR = '0;
    if (fetch)
      MEM_ADDR = ADDR_W'(32'(g_use >> 1) * 32'(DOTS) +
                         ((state == S_UNBLANK) ? 32'd0 : 32'(nbit)));
    gcp_n = (tick && tab_hit(lsc_n)) || (state == S_UNBLANK && tab_hit('0));
  end

  // Grid-select bits follow the pixels; the neighbouring pair does not wrap.
  always_comb begin
    int gj;
    ld_grid = 1'b0;
    gval    = 1'b0;
    sclr    = 1'b0;
    gj      = int'(nbit) - DOTS;
    if (state == S_SHIFT && tick) begin
      if (lsc == LSC_W'(BITS - 1)) sclr = 1'b1;
      else if (gj >= 0) begin
        ld_grid = 1'b1;
        gval    = (gj == int'(GRID)) ||
                  ((gj == int'(GRID) + 1) && (int'(GRID) + 1 < GRIDS));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ph      <= '0;
      lsc     <= '0;
      GRID    <= '0;
      fetch_q <= 1'b0;
      SCK     <= 1'b0;
      BLK     <= 1'b0;
      LAT     <= 1'b0;
      GCP     <= 1'b0;
      BUSY    <= 1'b0;
      OVR     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ph      <= ph_n;
      lsc     <= lsc_n;
      GRID    <= grid_n;
      fetch_q <= fetch;
      // Panel-facing controls are registered from next-state so they never glitch.
      SCK     <= (state_n == S_SHIFT) && (ph_n >= PH_HI);
      BLK     <= (state_n == S_BLANK) || (state_n == S_LATCH);
      LAT     <= (state_n == S_LATCH);
      GCP     <= gcp_n;
      BUSY    <= (state_n != S_IDLE);
      if (START && EN && state != S_IDLE) OVR <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vfd_tspi_lane u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .ld_mem   (fetch_q),
      .ld_grid  (ld_grid),
      .clr      (sclr),
      .mem_bit  (MEM_DATA[k]),
      .grid_bit (gval),
      .sout     (SOUT[k])
    );
  end
endmodule
